// File: rtl/lc3_pkg.sv
// lc3_pkg: constants and types shared by the LC-3 core.
//   - Opcode constants (instr[15:12]), also used by decode.
//   - Default reset PC.
//   - Fetch-stage FSM state encoding.
package lc3_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

  localparam logic [3:0] OPC_BR   = 4'b0000;
  localparam logic [3:0] OPC_ADD  = 4'b0001;
  localparam logic [3:0] OPC_LD   = 4'b0010;
  localparam logic [3:0] OPC_ST   = 4'b0011;
  localparam logic [3:0] OPC_JSR  = 4'b0100;
  localparam logic [3:0] OPC_AND  = 4'b0101;
  localparam logic [3:0] OPC_LDR  = 4'b0110;
  localparam logic [3:0] OPC_STR  = 4'b0111;
  localparam logic [3:0] OPC_RTI  = 4'b1000;
  localparam logic [3:0] OPC_NOT  = 4'b1001;
  localparam logic [3:0] OPC_LDI  = 4'b1010;
  localparam logic [3:0] OPC_STI  = 4'b1011;
  localparam logic [3:0] OPC_JMP  = 4'b1100;
  localparam logic [3:0] OPC_RES  = 4'b1101;
  localparam logic [3:0] OPC_LEA  = 4'b1110;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH,   // no request outstanding
    ST_WAIT,    // one request outstanding, response will be queued
    ST_DRAIN,   // one request outstanding, response will be discarded
    ST_HALTED   // HALT fetched, no more requests
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:12] == OPC_HALT;
  endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// lc3_fetch_fifo: DEPTH-entry circular buffer of {pc, instr} pairs.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push/i_wdata write one entry (caller guarantees not full)
//   i_pop          remove head when non-empty
//   i_flush        empty the buffer; wins over push/pop
//   o_valid/o_head head entry, driven from registered state only
//   o_count        number of stored entries
module lc3_fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [31:0]   i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [31:0]   o_head,
  output logic [CW-1:0] o_count
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = i_pop && (count != '0);
  assign o_valid = (count != '0);
  assign o_head  = mem[rd_ptr];
  assign o_count = count;

  // NOTE: the storage is reset because it is only DEPTH words and the head
  // word is visible on the outputs, which must read zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        mem[wr_ptr] <= i_wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      // Simultaneous push and pop leave the count unchanged.
      case ({i_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lc3_fetch.sv
// lc3_fetch: LC-3 instruction fetch stage.
//   i_clk, i_rst                  clock, synchronous active-high reset
//   o_mem_rd, o_mem_addr          one-cycle read request to instruction memory
//   i_mem_rvalid, i_mem_rdata     read response (single outstanding request)
//   o_valid, o_instr, o_pc, i_ready  queue head to decode, valid/ready handshake
//   i_redirect, i_redirect_pc     flush queue and restart fetch at new PC
//   o_halted                      HALT word fetched, fetching stopped
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_rd,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_rvalid,
  input  logic [15:0] i_mem_rdata,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_halted
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state;
  logic [15:0]   pc;
  logic [15:0]   req_pc;
  logic [CW-1:0] count;
  logic          push;
  logic [31:0]   head;

  // Only one request in flight and issue only with a free slot, so a push
  // can never meet a full queue.
  assign o_mem_rd   = (state == ST_FETCH) && (count < CW'(DEPTH)) && !i_redirect && !i_rst;
  assign o_mem_addr = pc;
  assign push       = (state == ST_WAIT) && i_mem_rvalid && !i_redirect;
  assign o_halted   = (state == ST_HALTED);

  // NOTE: all state is assigned with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (i_redirect) begin
      pc <= i_redirect_pc;
      // An in-flight request must still be absorbed; if its response lands
      // in this very cycle it is consumed (and dropped) here instead.
      if ((state == ST_WAIT || state == ST_DRAIN) && !i_mem_rvalid)
        state <= ST_DRAIN;
      else
        state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (o_mem_rd) begin
            req_pc <= pc;
            pc     <= pc + 16'd1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid)
            state <= is_halt(i_mem_rdata) ? ST_HALTED : ST_FETCH;
        end
        ST_DRAIN: begin
          if (i_mem_rvalid) state <= ST_FETCH;
        end
        default: state <= state;  // ST_HALTED: leave only via redirect/reset
      endcase
    end
  end

  lc3_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata ({req_pc, i_mem_rdata}),
    .i_pop   (i_ready),
    .i_flush (i_redirect),
    .o_valid (o_valid),
    .o_head  (head),
    .o_count (count)
  );

  assign o_pc    = head[31:16];
  assign o_instr = head[15:0];

endmodule

// File: tb/tb_lc3_fetch.sv
// tb_lc3_fetch: self-checking bench for lc3_fetch.
// A behavioural memory answers each request after a programmable latency; an
// expected-{pc,instr} queue is filled when a response should be kept and is
// compared whenever the DUT hands an entry over. Directed sequences check
// cycle timing, halt, redirect, PC wrap and reset-while-waiting.
module tb_lc3_fetch;
  import lc3_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic        i_mem_rvalid;
  logic [15:0] i_mem_rdata;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        i_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_halted;

  lc3_fetch #(.RESET_PC(16'h3000), .DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_mem_rd      (o_mem_rd),
    .o_mem_addr    (o_mem_addr),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_halted      (o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  bit          halt_en  = 1'b0;
  logic        resp_pend  = 1'b0;
  logic        resp_stale = 1'b0;
  int          resp_left  = 0;
  logic [15:0] resp_pc;
  logic [15:0] resp_data;
  logic [15:0] exp_pc = 16'h3000;
  logic [31:0] exp_q[$];
  int          n_issue = 0;

  logic        s_rd, s_valid, s_halted;
  logic [15:0] s_addr, s_pc, s_instr;

  typedef struct {
    logic        ready;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h3000: return 16'h1261;
      16'h3001: return halt_en ? 16'hF025 : 16'h5020;
      16'h3002: return 16'h9000;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle. Inputs for the cycle are already set by the caller.
  task automatic tick();
    logic got;
    got = 1'b0;
    if (resp_pend) begin
      resp_left--;
      if (resp_left == 0) got = 1'b1;
    end
    i_mem_rvalid = got;
    i_mem_rdata  = got ? resp_data : 16'hDEAD;
    #4;
    s_rd     = o_mem_rd;
    s_addr   = o_mem_addr;
    s_valid  = o_valid;
    s_pc     = o_pc;
    s_instr  = o_instr;
    s_halted = o_halted;
    if (!i_rst && !i_redirect && s_valid === 1'b1 && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: actual=%h required=none", {s_pc, s_instr});
      end else begin
        check("sb_head", {s_pc, s_instr}, exp_q.pop_front());
      end
    end
    if (got) begin
      resp_pend = 1'b0;
      if (!resp_stale && !i_redirect && !i_rst)
        exp_q.push_back({resp_pc, mem_word(resp_pc)});
    end
    if (i_rst || i_redirect) begin
      exp_q.delete();
      if (resp_pend) resp_stale = 1'b1;
      exp_pc = i_rst ? 16'h3000 : i_redirect_pc;
    end
    if (s_rd === 1'b1) begin
      check("mem_addr", {16'h0, s_addr}, {16'h0, exp_pc});
      check("single_outstanding", {31'h0, resp_pend}, 32'h0);
      resp_pend  = 1'b1;
      resp_stale = 1'b0;
      resp_left  = lat;
      resp_pc    = exp_pc;
      resp_data  = mem_word(s_addr);
      exp_pc     = exp_pc + 16'd1;
      n_issue++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_redirect = 1'b0;
    i_ready    = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    int first;
    logic [15:0] first_addr;
    logic seen_valid;

    i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0;
    i_mem_rvalid = 1'b0; i_mem_rdata = 16'h0;
    @(posedge i_clk);
    #1;

    // Table: latency 1, always ready, cycles 1..7 after reset.
    vecs[0] = '{1'b1, 1'b1, 16'h3000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h3001, 1'b1, 16'h3000, 16'h1261};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h3002, 1'b1, 16'h3001, 16'h5020};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 16'h3003, 1'b1, 16'h3002, 16'h9000};

    // 1: reset values, then basic streaming
    lat = 1; halt_en = 1'b0;
    do_reset();
    check("rst_valid",  {31'h0, s_valid},  32'h0);
    check("rst_instr",  {16'h0, s_instr},  32'h0);
    check("rst_pc",     {16'h0, s_pc},     32'h0);
    check("rst_halted", {31'h0, s_halted}, 32'h0);
    check("rst_mem_rd", {31'h0, s_rd},     32'h0);
    for (int i = 0; i < 7; i++) begin
      i_ready = vecs[i].ready;
      tick();
      check($sformatf("t1_rd_c%0d", i + 1), {31'h0, s_rd}, {31'h0, vecs[i].exp_rd});
      if (vecs[i].exp_rd)
        check($sformatf("t1_addr_c%0d", i + 1), {16'h0, s_addr}, {16'h0, vecs[i].exp_addr});
      check($sformatf("t1_valid_c%0d", i + 1), {31'h0, s_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("t1_head_c%0d", i + 1), {s_pc, s_instr},
              {vecs[i].exp_pc, vecs[i].exp_instr});
    end

    // 2: backpressure fills the queue, issue resumes after one pop
    do_reset();
    n_issue = 0;
    i_ready = 1'b0;
    repeat (8) tick();
    check("t2_issue_count", n_issue, 2);
    check("t2_hold", {15'h0, s_valid, s_pc}, {15'h0, 1'b1, 16'h3000});
    check("t2_hold_instr", {16'h0, s_instr}, 32'h1261);
    i_ready = 1'b1;
    tick();
    check("t2_no_rd_full", {31'h0, s_rd}, 32'h0);
    i_ready = 1'b0;
    tick();
    check("t2_rd_after_pop", {31'h0, s_rd}, 32'h1);
    check("t2_addr_after_pop", {16'h0, s_addr}, 32'h3002);
    i_ready = 1'b1;
    repeat (6) tick();

    // 3: redirect while a latency-3 request is outstanding
    lat = 3;
    do_reset();
    i_ready = 1'b1;
    tick();
    check("t3_rd_c1", {31'h0, s_rd}, 32'h1);
    i_redirect = 1'b1; i_redirect_pc = 16'h4000;
    tick();
    i_redirect = 1'b0;
    first = -1; first_addr = 16'h0; seen_valid = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (s_valid === 1'b1) seen_valid = 1'b1;
      if (s_rd === 1'b1 && first < 0) begin
        first = c;
        first_addr = s_addr;
      end
    end
    check("t3_valid_flushed", {31'h0, seen_valid}, 32'h0);
    check("t3_first_rd_cycle", first, 5);
    check("t3_first_addr", {16'h0, first_addr}, 32'h4000);
    repeat (10) tick();

    // 4: HALT word at 0x3001
    lat = 1; halt_en = 1'b1;
    do_reset();
    i_ready = 1'b1;
    n_issue = 0;
    repeat (5) tick();
    check("t4_halted", {31'h0, s_halted}, 32'h1);
    check("t4_head", {15'h0, s_valid, s_pc}, {15'h0, 1'b1, 16'h3001});
    check("t4_instr", {16'h0, s_instr}, 32'hF025);
    repeat (8) tick();
    check("t4_no_rd_halted", n_issue, 2);
    check("t4_still_halted", {31'h0, s_halted}, 32'h1);
    i_redirect = 1'b1; i_redirect_pc = 16'h3000;
    tick();
    i_redirect = 1'b0;
    tick();
    check("t4_halt_cleared", {31'h0, s_halted}, 32'h0);
    check("t4_resume_rd", {15'h0, s_rd, s_addr}, {15'h0, 1'b1, 16'h3000});
    repeat (6) tick();
    halt_en = 1'b0;

    // 5: PC wraps 0xFFFF -> 0x0000
    do_reset();
    i_ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 16'hFFFF;
    tick();
    check("t5_rd_gated", {31'h0, s_rd}, 32'h0);
    i_redirect = 1'b0;
    tick();
    check("t5_rd_ffff", {15'h0, s_rd, s_addr}, {15'h0, 1'b1, 16'hFFFF});
    tick();
    tick();
    check("t5_rd_0000", {15'h0, s_rd, s_addr}, {15'h0, 1'b1, 16'h0000});
    repeat (4) tick();

    // 6: reset while a response is due the next cycle
    lat = 2;
    do_reset();
    i_ready = 1'b0;
    repeat (4) tick();
    check("t6_pre_valid", {15'h0, s_valid, s_pc}, {15'h0, 1'b1, 16'h3000});
    check("t6_pre_rd", {15'h0, s_rd, s_addr}, {15'h0, 1'b1, 16'h3001});
    i_rst = 1'b1;
    tick();
    check("t6_rd_in_rst", {31'h0, s_rd}, 32'h0);
    i_rst = 1'b0;
    tick();
    check("t6_outs_reset", {s_pc, s_instr}, 32'h0);
    check("t6_valid_halt", {30'h0, s_valid, s_halted}, 32'h0);
    check("t6_restart_rd", {15'h0, s_rd, s_addr}, {15'h0, 1'b1, 16'h3000});
    tick();
    check("t6_stale_ignored", {31'h0, s_valid}, 32'h0);
    i_ready = 1'b1;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_fetch.md
# lc3_fetch

Instruction fetch stage of the LC-3 core. Owns the program counter, reads 16-bit instruction words from instruction memory over a single-outstanding request/response port, and buffers them in a 2-entry queue. It hands {pc, instr} pairs to the execute/decode core over a valid/ready handshake. It accepts redirects (jumps, branches, restart) from downstream and stops fetching by itself after a HALT (opcode 4'b1111) word.

## Interface
- RESET_PC, 16'h3000, PC loaded on reset
- DEPTH, 2, instruction queue entries (≥2)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_mem_rd  out  1  read request, one-cycle pulse per fetch
- o_mem_addr  out  16  word address, valid when o_mem_rd=1
- i_mem_rvalid  in  1  read data valid, ≥1 cycle after request
- i_mem_rdata  in  16  instruction word, valid with i_mem_rvalid
- o_valid  out  1  queue head valid to downstream
- o_instr  out  16  queue head instruction
- o_pc  out  16  address of o_instr
- i_ready  in  1  downstream accepts head; pop when o_valid & i_ready
- i_redirect  in  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  in  16  new PC
- o_halted  out  1  HALT word fetched, fetch stopped

## Operation
- States: FETCH (no request outstanding), WAIT (one request outstanding), DRAIN (outstanding response to be discarded), HALTED.
- o_mem_rd = (state==FETCH) & (count<DEPTH) & !i_redirect & !i_rst; o_mem_addr = pc. On issue: pc <= pc+1, wrapping 16'hFFFF→16'h0000; FETCH→WAIT.
- WAIT + i_mem_rvalid: push {issue pc, rdata}. If rdata[15:12]==4'b1111 go to HALTED and set o_halted; else go to FETCH.
- Invariant: at most one outstanding request. Issue only when count<DEPTH, so a push never meets a full queue.
- Redirect, highest priority: flush the queue (count<=0, o_valid=0) and set pc<=i_redirect_pc. Clear o_halted. Next state: WAIT→DRAIN, DRAIN→DRAIN, FETCH/HALTED→FETCH. A response arriving in the redirect cycle is discarded.
- DRAIN + i_mem_rvalid: discard data, go to FETCH.
- i_mem_rvalid in FETCH or HALTED is ignored; this covers a stale response after reset.
- Push and pop in the same cycle: count unchanged and order preserved. A pop in a redirect cycle has no separate effect.
- HALTED: no requests. Queue still drains normally. Exit only via redirect or reset.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, count=0, o_valid=0, o_instr=0, o_pc=0, o_halted=0, o_mem_rd=0 during reset.
- The first request is issued in the first cycle after i_rst deasserts, at addr RESET_PC.
- Response in cycle N is pushed at the end of N, so o_valid=1 in N+1. Latency from request to o_valid is memory latency + 1.
- The next request is issued in cycle N+1. Peak rate is one instruction per 2 cycles at memory latency 1.
- o_valid/o_instr/o_pc are driven from registered queue state with no combinational path from i_ready. o_mem_rd is combinational from state, count, i_redirect and i_rst.
- A redirect in cycle R means o_valid=0 in R+1. The first request to i_redirect_pc goes out in R+1 if the state was FETCH/HALTED, or the cycle after the stale response if it was WAIT.
- While o_valid=1 and i_ready=0, o_instr/o_pc hold stable.

## Structure
- Shared package lc3_pkg: OPC_HALT=4'b1111 and other opcode constants, the default RESET_PC, and the fetch state enum (ST_FETCH, ST_WAIT, ST_DRAIN, ST_HALTED). The core's decode uses the same opcode constants.
- Sub-module lc3_fetch_fifo: DEPTH-entry circular buffer of 32-bit {pc,instr} with push, pop, flush and count, head registered. The top level holds the PC, the FSM and the memory port.

## Test plan
- Reset, memory latency 1, i_ready=1, words 0x1261, 0x5020, 0x9000 at 0x3000..2 → o_mem_addr 0x3000, 0x3001, 0x3002 on cycles 1, 3, 5. o_valid with o_pc=0x3000/o_instr=0x1261 on cycle 3.
- i_ready=0, latency 1 → exactly 2 requests issued, count=2, then no o_mem_rd until a pop. After the pop, the next request goes out the following cycle.
- Latency 3, redirect to 0x4000 while in WAIT → stale response discarded and o_valid stays 0. First request after the stale response is to 0x4000.
- Word 0xF025 fetched at 0x3001 → o_halted=1, no further o_mem_rd. 0xF025 is still delivered with o_pc=0x3001. Redirect to 0x3000 clears o_halted and fetch resumes.
- redirect_pc=0xFFFF → fetches 0xFFFF then 0x0000.
- Assert i_rst while in WAIT with a response due next cycle → all outputs return to reset values, the stale response is ignored, and fetch restarts at RESET_PC.
